// File: rtl/scalar_mul_pkg.sv
// Shared types for the scalar-multiplication sequencer: FSM states, ladder mode,
// and the bit-counter width helper.
package scalar_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DBL  = 2'd1,
    S_ADD  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_DA = 1'b0,
    MODE_CT = 1'b1
  } mode_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scalar_msb_find.sv
// Priority encoder: index of the most significant set bit of i_m, plus a zero flag.
module scalar_msb_find #(
  parameter int NBITS = 255,
  parameter int CW    = 8
) (
  input  logic [NBITS-1:0] i_m,
  output logic [CW-1:0]    o_idx,
  output logic             o_zero
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NBITS; i++)
      if (i_m[i]) o_idx = CW'(i);
  end

  assign o_zero = ~|i_m;

endmodule

// File: rtl/scalar_mul_ladder.sv
// MSB-first double-and-add / double-and-always-add sequencer driving an external
// projective point-add/double engine. R is exposed directly on o_x/o_y/o_z.
module scalar_mul_ladder
  import scalar_mul_pkg::*;
#(
  parameter int W       = 255,
  parameter int NBITS   = 255,
  parameter int SKIP_LZ = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [NBITS-1:0] i_M,
  input  logic [W-1:0]     i_x,
  input  logic [W-1:0]     i_y,
  output logic [W-1:0]     o_x,
  output logic [W-1:0]     o_y,
  output logic [W-1:0]     o_z,
  output logic             o_busy,
  output logic             o_finished,
  output logic             o_pa_start,
  output logic             o_pa_doubling,
  output logic [W-1:0]     o_pa_x1,
  output logic [W-1:0]     o_pa_y1,
  output logic [W-1:0]     o_pa_z1,
  output logic [W-1:0]     o_pa_x2,
  output logic [W-1:0]     o_pa_y2,
  output logic [W-1:0]     o_pa_z2,
  input  logic [W-1:0]     i_pa_x3,
  input  logic [W-1:0]     i_pa_y3,
  input  logic [W-1:0]     i_pa_z3,
  input  logic             i_pa_finished
);

  localparam int          CW  = cnt_w(NBITS);
  localparam logic [W-1:0] ONE = W'(1);

  state_e           r_state;
  mode_e            r_mode;
  logic [NBITS-1:0] r_M;
  logic [W-1:0]     r_px, r_py;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_x, r_y, r_z;
  logic             r_busy, r_fin, r_nop;
  logic             r_pa_start, r_pa_dbl;
  logic [W-1:0]     r_pa_x1, r_pa_y1, r_pa_z1, r_pa_x2, r_pa_y2, r_pa_z2;

  logic [CW-1:0]    w_k;
  logic             w_mzero, w_bit, w_take, w_go_add;
  logic [W-1:0]     w_nx, w_ny, w_nz;

  scalar_msb_find #(.NBITS(NBITS), .CW(CW)) u_msb (
    .i_m   (i_M),
    .o_idx (w_k),
    .o_zero(w_mzero)
  );

  // In constant-time mode an add for a zero bit is still issued, but its result is dropped.
  assign w_bit    = r_M[r_cnt];
  assign w_take   = (r_state == S_DBL) || (r_mode == MODE_DA) || w_bit;
  assign w_nx     = w_take ? i_pa_x3 : r_x;
  assign w_ny     = w_take ? i_pa_y3 : r_y;
  assign w_nz     = w_take ? i_pa_z3 : r_z;
  assign w_go_add = (r_state == S_DBL) && ((r_mode == MODE_CT) || w_bit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_mode     <= MODE_DA;
      r_M        <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_cnt      <= CW'(NBITS - 1);
      r_x        <= '0;
      r_y        <= ONE;
      r_z        <= ONE;
      r_busy     <= 1'b0;
      r_fin      <= 1'b0;
      r_nop      <= 1'b0;
      r_pa_start <= 1'b0;
      r_pa_dbl   <= 1'b0;
      r_pa_x1    <= '0;
      r_pa_y1    <= '0;
      r_pa_z1    <= '0;
      r_pa_x2    <= '0;
      r_pa_y2    <= '0;
      r_pa_z2    <= '0;
    end else begin
      r_fin      <= 1'b0;
      r_pa_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // r_nop: accepted scalar needed no engine op; finish one cycle later.
          if (r_nop) begin
            r_nop  <= 1'b0;
            r_busy <= 1'b0;
            r_fin  <= 1'b1;
          end else if (i_start) begin
            r_busy   <= 1'b1;
            r_mode   <= mode_e'(i_mode);
            r_M      <= i_M;
            r_px     <= i_x;
            r_py     <= i_y;
            r_pa_dbl <= 1'b1;
            if (i_mode == MODE_DA && SKIP_LZ != 0 && !w_mzero) begin
              r_x <= i_x;
              r_y <= i_y;
              r_z <= ONE;
              if (w_k == '0) begin
                r_nop <= 1'b1;
              end else begin
                r_cnt      <= w_k - 1'b1;
                r_state    <= S_DBL;
                r_pa_start <= 1'b1;
                r_pa_x1    <= i_x;
                r_pa_y1    <= i_y;
                r_pa_z1    <= ONE;
              end
            end else begin
              r_x <= '0;
              r_y <= ONE;
              r_z <= ONE;
              if (i_mode == MODE_DA && SKIP_LZ != 0) begin
                r_nop <= 1'b1;
              end else begin
                r_cnt      <= CW'(NBITS - 1);
                r_state    <= S_DBL;
                r_pa_start <= 1'b1;
                r_pa_x1    <= '0;
                r_pa_y1    <= ONE;
                r_pa_z1    <= ONE;
              end
            end
          end
        end
        S_DBL, S_ADD: begin
          if (i_pa_finished) begin
            r_x <= w_nx;
            r_y <= w_ny;
            r_z <= w_nz;
            if (w_go_add) begin
              r_state    <= S_ADD;
              r_pa_start <= 1'b1;
              r_pa_dbl   <= 1'b0;
              r_pa_x1    <= w_nx;
              r_pa_y1    <= w_ny;
              r_pa_z1    <= w_nz;
              r_pa_x2    <= r_px;
              r_pa_y2    <= r_py;
              r_pa_z2    <= ONE;
            end else if (r_cnt == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_fin   <= 1'b1;
            end else begin
              r_cnt      <= r_cnt - 1'b1;
              r_state    <= S_DBL;
              r_pa_start <= 1'b1;
              r_pa_dbl   <= 1'b1;
              r_pa_x1    <= w_nx;
              r_pa_y1    <= w_ny;
              r_pa_z1    <= w_nz;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_z           = r_z;
  assign o_busy        = r_busy;
  assign o_finished    = r_fin;
  assign o_pa_start    = r_pa_start;
  assign o_pa_doubling = r_pa_dbl;
  assign o_pa_x1       = r_pa_x1;
  assign o_pa_y1       = r_pa_y1;
  assign o_pa_z1       = r_pa_z1;
  assign o_pa_x2       = r_pa_x2;
  assign o_pa_y2       = r_pa_y2;
  assign o_pa_z2       = r_pa_z2;

endmodule

// File: tb/tb_scalar_mul_ladder.sv
// Scoreboard bench for scalar_mul_ladder with a 1-cycle stub engine whose x
// coordinate tracks M*x mod 2^W (double = 2*x1, add = x1+x2, y/z pass through).
module tb_scalar_mul_ladder;
  localparam int W = 16;
  localparam int NBITS = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [NBITS-1:0] M = '0;
  logic [W-1:0]     px = '0, py = '0;
  logic [W-1:0]     o_x, o_y, o_z;
  logic             o_busy, o_finished, o_pa_start, o_pa_doubling;
  logic [W-1:0]     pa_x1, pa_y1, pa_z1, pa_x2, pa_y2, pa_z2;
  logic [W-1:0]     x3 = '0, y3 = '0, z3 = '0;
  logic             eng_fin = 1'b0, inj_fin = 1'b0;
  int               cyc = 0;
  int               n_tests = 0, n_fail = 0;

  typedef struct {
    string      name;
    logic [W-1:0] x, y, z;
    int         ops, dbl, lat, tacc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scalar_mul_ladder #(.W(W), .NBITS(NBITS), .SKIP_LZ(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_M(M),
    .i_x(px), .i_y(py), .o_x(o_x), .o_y(o_y), .o_z(o_z),
    .o_busy(o_busy), .o_finished(o_finished), .o_pa_start(o_pa_start),
    .o_pa_doubling(o_pa_doubling),
    .o_pa_x1(pa_x1), .o_pa_y1(pa_y1), .o_pa_z1(pa_z1),
    .o_pa_x2(pa_x2), .o_pa_y2(pa_y2), .o_pa_z2(pa_z2),
    .i_pa_x3(x3), .i_pa_y3(y3), .i_pa_z3(z3),
    .i_pa_finished(eng_fin | inj_fin)
  );

  always @(posedge clk) begin
    eng_fin <= 1'b0;
    if (o_pa_start) begin
      eng_fin <= 1'b1;
      x3 <= o_pa_doubling ? W'(pa_x1 << 1) : pa_x1 + pa_x2;
      y3 <= pa_y1;
      z3 <= pa_z1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Caller sits on a negedge; holds i_start for exactly one cycle.
  task automatic issue(input string nm, input logic md, input logic [7:0] m,
                       input logic [W-1:0] ix, input logic [W-1:0] iy,
                       input logic [W-1:0] ex, input logic [W-1:0] ey,
                       input int nops, input int ndbl, input int lat, input bit push);
    exp_t e;
    start = 1'b1; mode = md; M = m; px = ix; py = iy;
    if (push) begin
      e.name = nm; e.x = ex; e.y = ey; e.z = W'(1);
      e.ops = nops; e.dbl = ndbl; e.lat = lat; e.tacc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fin(input string nm);
    int n = 0;
    while (!o_finished && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_finished) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no finished expected finished within 200 cycles", nm);
    end
  endtask

  initial begin : monitor
    int ops = 0, dbl = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ops = 0; dbl = 0;
      end else begin
        if (o_pa_start) begin
          ops++;
          if (o_pa_doubling) dbl++;
        end
        if (o_finished) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_finished: got finished pulse expected none at cycle %0d", cyc);
          end else begin
            e = sb.pop_front();
            check({e.name, "_x"}, 32'(o_x), 32'(e.x));
            check({e.name, "_y"}, 32'(o_y), 32'(e.y));
            check({e.name, "_z"}, 32'(o_z), 32'(e.z));
            check({e.name, "_ops"}, ops, e.ops);
            check({e.name, "_dbl"}, dbl, e.dbl);
            check({e.name, "_lat"}, cyc - e.tacc, e.lat);
          end
          ops = 0; dbl = 0;
        end
      end
    end
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(o_x), 0);
    check("rst_y", 32'(o_y), 1);
    check("rst_z", 32'(o_z), 1);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_fin", 32'(o_finished), 0);
    check("rst_pa_start", 32'(o_pa_start), 0);
    rst = 1'b0;
    @(negedge clk);

    // 0xB5 = 181, 181*3 = 543; k=7, popcount 5 -> 11 ops, 7 doubles
    issue("m0_b5", 1'b0, 8'hB5, 16'd3, 16'd9, 16'd543, 16'd9, 11, 7, 23, 1'b1);
    wait_fin("m0_b5");
    // back-to-back into the finished cycle; no-op cases finish 2 cycles after accept
    issue("m0_00", 1'b0, 8'h00, 16'd4, 16'd4, 16'd0, 16'd1, 0, 0, 2, 1'b1);
    wait_fin("m0_00");
    issue("m0_01", 1'b0, 8'h01, 16'd7, 16'd2, 16'd7, 16'd2, 0, 0, 2, 1'b1);
    wait_fin("m0_01");
    // constant-time: always 16 ops, 33 cycles, y stays at identity 1
    issue("m1_01", 1'b1, 8'h01, 16'd3, 16'd9, 16'd3, 16'd1, 16, 8, 33, 1'b1);
    wait_fin("m1_01");
    issue("m1_b5", 1'b1, 8'hB5, 16'd3, 16'd9, 16'd543, 16'd1, 16, 8, 33, 1'b1);
    wait_fin("m1_b5");
    @(negedge clk);

    // start pulse while busy must be ignored
    issue("busy_ign", 1'b0, 8'hB5, 16'd3, 16'd9, 16'd543, 16'd9, 11, 7, 23, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; mode = 1'b1; M = 8'hFF; px = 16'd1; py = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_fin("busy_ign");
    @(negedge clk);

    // engine finished pulse while idle must be ignored
    inj_fin = 1'b1;
    @(negedge clk);
    inj_fin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_pa_start", 32'(o_pa_start), 0);
      check("idle_busy", 32'(o_busy), 0);
    end
    check("idle_x", 32'(o_x), 543);

    // reset in the middle of an add
    issue("abort", 1'b0, 8'hB5, 16'd3, 16'd9, 16'd0, 16'd0, 0, 0, 0, 1'b0);
    n = 0;
    while (!(o_pa_start && !o_pa_doubling) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_add", 32'(o_pa_start && !o_pa_doubling), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_x", 32'(o_x), 0);
    check("abort_y", 32'(o_y), 1);
    check("abort_z", 32'(o_z), 1);
    check("abort_busy", 32'(o_busy), 0);
    check("abort_pa_start", 32'(o_pa_start), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue("post_rst_02", 1'b0, 8'h02, 16'd5, 16'd6, 16'd10, 16'd6, 1, 1, 3, 1'b1);
    wait_fin("post_rst_02");

    repeat (6) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
